// File: rtl/fb_write_ctrl_if.sv
// Bus bundle between the framebuffer write controller and its requesters.
//
// Handshake semantics:
//   cpu_we      valid-only: the controller accepts a CPU store in every cycle
//               cpu_we is high.  There is no ready; a store is never stalled.
//   fill_start  valid-only: taken only while the controller is idle
//               (fill_busy=0, fill_done=0); ignored at any other time.
//   fill_abort  cancels an accepted fill while fill_busy=1.
//   fill_busy   high while a fill is being walked.
//   fill_done   one-cycle completion pulse; absent for aborted fills.
//   we          one framebuffer write per cycle it is high; haddr/vaddr/wdata
//               are meaningful only in those cycles.
interface fb_write_ctrl_if;
  logic        cpu_we;
  logic [9:0]  cpu_haddr;
  logic [9:0]  cpu_vaddr;
  logic [11:0] cpu_wdata;
  logic        fill_start;
  logic        fill_abort;
  logic [9:0]  fill_x0;
  logic [9:0]  fill_y0;
  logic [9:0]  fill_x1;
  logic [9:0]  fill_y1;
  logic [11:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        we;
  logic [9:0]  haddr;
  logic [9:0]  vaddr;
  logic [11:0] wdata;

  // Requester side: issues stores and fill commands, observes the write port.
  modport master (
    output cpu_we, cpu_haddr, cpu_vaddr, cpu_wdata,
    output fill_start, fill_abort, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    input  fill_busy, fill_done, we, haddr, vaddr, wdata
  );

  // Controller side.
  modport slave (
    input  cpu_we, cpu_haddr, cpu_vaddr, cpu_wdata,
    input  fill_start, fill_abort, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    output fill_busy, fill_done, we, haddr, vaddr, wdata
  );
endinterface

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-port arbiter: CPU single-pixel stores always win; a
// rectangle-fill engine uses every remaining cycle to write its rectangle in
// raster order and pulses fill_done when the last pixel is written.
module fb_write_ctrl #(
  parameter int HSIZE = 320,
  parameter int VSIZE = 240
) (
  input  logic              rclk,
  input  logic              rst,
  fb_write_ctrl_if.slave    bus,
  output logic [1:0]        dbg_state
);

  localparam logic [9:0] HMAX = 10'(HSIZE - 1);
  localparam logic [9:0] VMAX = 10'(VSIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  // Cursor and the rectangle captured at start (far corner already clamped).
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [9:0]  x0_r;
  logic [9:0]  y0_r;
  logic [9:0]  x1_r;
  logic [9:0]  y1_r;
  logic [11:0] color_r;

  logic [9:0]  x1c_in;
  logic [9:0]  y1c_in;
  logic        empty_in;
  logic        fill_go;
  logic        last_px;

  logic        we_r;
  logic [9:0]  haddr_r;
  logic [9:0]  vaddr_r;
  logic [11:0] wdata_r;

  // Clamp the requested far corner to the screen and detect empty rectangles.
  always_comb begin
    x1c_in   = (bus.fill_x1 > HMAX) ? HMAX : bus.fill_x1;
    y1c_in   = (bus.fill_y1 > VMAX) ? VMAX : bus.fill_y1;
    empty_in = (bus.fill_x0 > x1c_in) || (bus.fill_y0 > y1c_in);
  end

  // A fill pixel goes out only in FILL when neither the CPU nor an abort claims the cycle.
  assign fill_go = (state == FILL) && !bus.fill_abort && !bus.cpu_we;
  assign last_px = (cx == x1_r) && (cy == y1_r);

  // State register.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; abort outranks completion of the last pixel.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.fill_start) state_nx = empty_in ? DONE : FILL;
      FILL: begin
        if (bus.fill_abort)          state_nx = IDLE;
        else if (fill_go && last_px) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the rectangle on start and walk the cursor in raster order.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      cx      <= '0;
      cy      <= '0;
      x0_r    <= '0;
      y0_r    <= '0;
      x1_r    <= '0;
      y1_r    <= '0;
      color_r <= '0;
    end else if (state == IDLE && bus.fill_start) begin
      x0_r    <= bus.fill_x0;
      y0_r    <= bus.fill_y0;
      x1_r    <= x1c_in;
      y1_r    <= y1c_in;
      color_r <= bus.fill_color;
      cx      <= bus.fill_x0;
      cy      <= bus.fill_y0;
    end else if (fill_go && !last_px) begin
      if (cx == x1_r) begin
        cx <= x0_r;
        cy <= cy + 10'd1;
      end else begin
        cx <= cx + 10'd1;
      end
    end
  end

  // Registered write port: CPU store first, else the fill pixel, else idle.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      haddr_r <= '0;
      vaddr_r <= '0;
      wdata_r <= '0;
    end else if (bus.cpu_we) begin
      we_r    <= 1'b1;
      haddr_r <= bus.cpu_haddr;
      vaddr_r <= bus.cpu_vaddr;
      wdata_r <= bus.cpu_wdata;
    end else if (fill_go) begin
      we_r    <= 1'b1;
      haddr_r <= cx;
      vaddr_r <= cy;
      wdata_r <= color_r;
    end else begin
      we_r    <= 1'b0;
    end
  end

  assign bus.we        = we_r;
  assign bus.haddr     = haddr_r;
  assign bus.vaddr     = vaddr_r;
  assign bus.wdata     = wdata_r;
  assign bus.fill_busy = (state == FILL);
  assign bus.fill_done = (state == DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: directed scenarios plus randomized traffic, checked
// by a monitor against expectations queued by the stimulus side.
module tb_fb_write_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_DONE = 2;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rst  = 1'b0;
  always #5 rclk = ~rclk;

  fb_write_ctrl_if bus ();
  logic [1:0] dbg_state;

  fb_write_ctrl #(.HSIZE(320), .VSIZE(240)) dut (
    .rclk      (rclk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];   // expected writes {haddr, vaddr, wdata}
  logic [2:0]  flag_q[$];  // expected per-cycle {we, fill_busy, fill_done}
  logic [19:0] pix_q[$];   // pixels the reference fill still has to write {x, y}
  int          m_state = M_IDLE;
  logic [11:0] m_color = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [2:0]  mon_f;
  logic [31:0] mon_e;
  always @(negedge rclk) begin
    if (rst === 1'b1 && flag_q.size() > 0) begin
      mon_f = flag_q.pop_front();
      check("we", 32'(bus.we), 32'(mon_f[2]));
      check("fill_busy", 32'(bus.fill_busy), 32'(mon_f[1]));
      check("fill_done", 32'(bus.fill_done), 32'(mon_f[0]));
      if (bus.we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {bus.haddr, bus.vaddr, bus.wdata}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {bus.haddr, bus.vaddr, bus.wdata}, mon_e);
        end
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic drive(input logic c_we, input int c_h, input int c_v, input int c_d,
                       input logic st, input logic ab,
                       input int rx0, input int ry0, input int rx1, input int ry1, input int rc);
    logic       e_we;
    logic [19:0] p;
    int x1c, y1c;
    @(negedge rclk);
    #1;
    bus.cpu_we     = c_we;
    bus.cpu_haddr  = 10'(c_h);
    bus.cpu_vaddr  = 10'(c_v);
    bus.cpu_wdata  = 12'(c_d);
    bus.fill_start = st;
    bus.fill_abort = ab;
    if (st) begin
      bus.fill_x0 = 10'(rx0); bus.fill_y0 = 10'(ry0);
      bus.fill_x1 = 10'(rx1); bus.fill_y1 = 10'(ry1);
      bus.fill_color = 12'(rc);
    end else begin
      bus.fill_x0 = 10'($urandom_range(0, 1023)); bus.fill_y0 = 10'($urandom_range(0, 1023));
      bus.fill_x1 = 10'($urandom_range(0, 1023)); bus.fill_y1 = 10'($urandom_range(0, 1023));
      bus.fill_color = 12'($urandom_range(0, 4095));
    end
    // Reference: CPU stores always go out; the fill takes leftover FILL cycles.
    e_we = 1'b0;
    if (c_we) begin
      exp_q.push_back({10'(c_h), 10'(c_v), 12'(c_d)});
      e_we = 1'b1;
    end
    case (m_state)
      M_IDLE: if (st) begin
        x1c = (rx1 > 319) ? 319 : rx1;
        y1c = (ry1 > 239) ? 239 : ry1;
        pix_q.delete();
        for (int y = ry0; y <= y1c; y++)
          for (int x = rx0; x <= x1c; x++)
            pix_q.push_back({10'(x), 10'(y)});
        m_color = 12'(rc);
        m_state = (pix_q.size() == 0) ? M_DONE : M_FILL;
      end
      M_FILL: begin
        if (ab) begin
          pix_q.delete();
          m_state = M_IDLE;
        end else if (!c_we) begin
          p = pix_q.pop_front();
          exp_q.push_back({p, m_color});
          e_we = 1'b1;
          if (pix_q.size() == 0) m_state = M_DONE;
        end
      end
      default: m_state = M_IDLE;
    endcase
    flag_q.push_back({e_we, m_state == M_FILL, m_state == M_DONE});
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic cpu(input int h, input int v, input int d);
    drive(1'b1, h, v, d, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic start(input int x0, input int y0, input int x1, input int y1, input int c);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, x0, y0, x1, y1, c);
  endtask

  task automatic rand_start_pulse();
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, $urandom_range(0, 50), $urandom_range(0, 50),
          $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 4095));
  endtask

  // Drive idle cycles until the reference fill has finished; start_pct adds ignored start pulses.
  task automatic wait_idle(input int budget, input int start_pct);
    int n = 0;
    while (m_state != M_IDLE && n < budget) begin
      if ($urandom_range(0, 99) < start_pct) rand_start_pulse();
      else idle();
      n++;
    end
    if (m_state != M_IDLE) begin
      failures++;
      $display("FAIL wait_idle: fill still running after %0d cycles", budget);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},    32'(bus.we),        32'd0);
    check({tag, "_haddr"}, 32'(bus.haddr),     32'd0);
    check({tag, "_vaddr"}, 32'(bus.vaddr),     32'd0);
    check({tag, "_wdata"}, 32'(bus.wdata),     32'd0);
    check({tag, "_busy"},  32'(bus.fill_busy), 32'd0);
    check({tag, "_done"},  32'(bus.fill_done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, x0, y0, x1, y1;
    bus.cpu_we = 1'b0; bus.cpu_haddr = '0; bus.cpu_vaddr = '0; bus.cpu_wdata = '0;
    bus.fill_start = 1'b0; bus.fill_abort = 1'b0;
    bus.fill_x0 = '0; bus.fill_y0 = '0; bus.fill_x1 = '0; bus.fill_y1 = '0;
    bus.fill_color = '0;

    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge rclk);
    #1 rst = 1'b1;

    // CPU pass-through while idle.
    cpu(5, 7, 12'hABC);
    idle(); idle();

    // Small fill, no contention.
    start(10, 20, 11, 21, 12'h0F0);
    wait_idle(20, 0);
    idle();

    // Same fill with two CPU stores in the middle.
    start(10, 20, 11, 21, 12'h0F0);
    idle();
    cpu(100, 101, 12'h111);
    cpu(102, 103, 12'h222);
    wait_idle(20, 0);
    idle();

    // Clipped fill then empty fill.
    start(318, 239, 400, 300, 12'h5A5);
    wait_idle(20, 0);
    start(20, 0, 10, 5, 12'h777);
    wait_idle(5, 0);
    idle();

    // Abort after three writes of a 100-pixel fill, then a new fill is accepted.
    start(0, 0, 9, 9, 12'h321);
    idle(); idle(); idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
    idle(); idle();
    start(50, 60, 52, 60, 12'hF00);
    wait_idle(20, 0);
    idle();

    // Randomized fills with CPU contention, aborts and ignored starts.
    for (int it = 0; it < 30; it++) begin
      x0 = $urandom_range(0, 330);
      y0 = $urandom_range(0, 245);
      x1 = x0 + $urandom_range(0, 8) - 2;
      y1 = y0 + $urandom_range(0, 5) - 1;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      start(x0, y0, x1, y1, $urandom_range(0, 4095));
      for (int n = 0; n < 400 && m_state != M_IDLE; n++) begin
        r = $urandom_range(0, 99);
        if (r < 30)      cpu($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4095));
        else if (r < 32) drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        else if (r < 37) rand_start_pulse();
        else             idle();
      end
      wait_idle(10, 0);
      if ($urandom_range(0, 1) == 1) cpu($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4095));
      idle();
    end

    // Full-screen clear with stray start pulses.
    start(0, 0, 319, 239, 12'h000);
    wait_idle(80000, 1);
    idle();

    // Reset in the middle of a fill: outputs drop at once.
    start(0, 0, 50, 50, 12'hEEE);
    idle(); idle(); idle();
    @(negedge rclk);
    #1;
    rst = 1'b0;
    bus.cpu_we = 1'b0; bus.fill_start = 1'b0; bus.fill_abort = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete(); flag_q.delete(); pix_q.delete();
    m_state = M_IDLE;
    repeat (2) @(negedge rclk);
    #1 rst = 1'b1;
    idle(); idle();
    cpu(9, 8, 12'h123);
    start(1, 1, 2, 1, 12'h0AA);
    wait_idle(20, 0);
    idle(); idle();

    repeat (2) @(negedge rclk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("flag_q_drained", 32'(flag_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
